// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DATA memory port arbiter: FSM states, owner encoding,
// the latched memory transaction and the data-streak update rule.
package mem_arb_pkg;

    localparam int OWN_W   = 2;
    localparam int XACT_AW = 32;
    localparam int XACT_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef enum logic [OWN_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef struct packed {
        logic               we;
        logic [3:0]         be;
        logic [XACT_AW-1:0] addr;
        logic [XACT_DW-1:0] wdata;
    } mem_xact_t;

    // Streak after a DATA grant: counts only while fetch is waiting, saturates at max.
    function automatic logic [3:0] streak_next(input logic [3:0] cur,
                                               input logic [3:0] max,
                                               input logic       if_pend);
        logic [3:0] nxt;
        if (!if_pend) begin
            nxt = 4'd0;
        end else if (cur >= max) begin
            nxt = max;
        end else begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between the fetch port and the data port.
// Data wins by default; a streak counter hands the port to fetch after MAX_D_STREAK data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [AW-1:0]    if_addr,
    output logic [DW-1:0]    if_rdata,
    output logic             if_ready,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [3:0]       d_be,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    output logic [DW-1:0]    d_rdata,
    output logic             d_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [DW-1:0]    mem_rdata,
    output logic [OWN_W-1:0] owner
);

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    arb_state_t    state_q;
    owner_t        owner_q;
    mem_xact_t     xact_q;
    logic [3:0]    streak_q;
    logic          mem_req_q;
    logic          if_ready_q;
    logic          d_ready_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;

    logic          if_wins_s;

    assign if_wins_s = if_req && (streak_q == MAX_S);

    // Arbitration FSM: latch a request, hold it on the memory until granted, await the response, pulse ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            xact_q     <= '0;
            streak_q   <= 4'd0;
            mem_req_q  <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_req && !if_wins_s) begin
                        xact_q    <= '{we: d_we, be: d_be,
                                       addr: XACT_AW'(d_addr), wdata: XACT_DW'(d_wdata)};
                        owner_q   <= OWN_D;
                        mem_req_q <= 1'b1;
                        streak_q  <= streak_next(streak_q, MAX_S, if_req);
                        state_q   <= REQ;
                    end else if (if_req) begin
                        xact_q    <= '{we: 1'b0, be: 4'h0,
                                       addr: XACT_AW'(if_addr), wdata: '0};
                        owner_q   <= OWN_IF;
                        mem_req_q <= 1'b1;
                        streak_q  <= 4'd0;
                        state_q   <= REQ;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end else begin
                        state_q   <= REQ;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            d_rdata_q  <= mem_rdata;
                            d_ready_q  <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                RESP: begin
                    owner_q <= OWN_NONE;
                    state_q <= IDLE;
                end
                default: begin
                    owner_q   <= OWN_NONE;
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // A fetch flushed during its response cycle must not see a completion.
    assign if_ready  = if_ready_q & if_req;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = xact_q.we;
    assign mem_be    = xact_q.be;
    assign mem_addr  = AW'(xact_q.addr);
    assign mem_wdata = DW'(xact_q.wdata);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small memory model with programmable
// grant/response delays, a grant log and ready-pulse monitors.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  owner;

    mem_port_arbiter #(.MAX_D_STREAK(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  own;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    gnt_t        gq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          gnt_dly  = 0;
    int          rv_dly   = 0;
    int          if_rdy_cnt = 0;
    int          d_rdy_cnt  = 0;
    int          last_if_cyc = 0;
    int          last_d_cyc  = 0;
    logic [31:0] last_if_rdata = 32'h0;
    logic [31:0] last_d_rdata  = 32'h0;
    int          dup_cnt  = 0;
    logic        prev_gnt = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        else return a + 32'h1000_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cnt(input string tag, input bit is_d, input int target, input int budget);
        int n = 0;
        while (((is_d ? d_rdy_cnt : if_rdy_cnt) < target) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, 64'((is_d ? d_rdy_cnt : if_rdy_cnt) >= target), 64'd1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grant after gnt_dly waiting cycles, respond rv_dly cycles after the grant cycle.
    initial begin
        int   m_cnt;
        bit   m_wait;
        logic [31:0] m_addr;
        m_cnt = 0; m_wait = 1'b0; m_addr = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (!m_wait) begin
                if (mem_req) begin
                    if (m_cnt == gnt_dly) begin
                        mem_gnt = 1'b1;
                        gq.push_back('{own: owner, we: mem_we, be: mem_be,
                                       addr: mem_addr, wdata: mem_wdata});
                        m_addr = mem_addr;
                        m_wait = 1'b1;
                        m_cnt  = 0;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    m_cnt = 0;
                end
            end else begin
                if (m_cnt == rv_dly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(m_addr);
                    m_wait     = 1'b0;
                    m_cnt      = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Ready-pulse and duplicate-request monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (if_ready) begin
            if_rdy_cnt++;
            last_if_rdata = if_rdata;
            last_if_cyc   = cyc;
        end
        if (d_ready) begin
            d_rdy_cnt++;
            last_d_rdata = d_rdata;
            last_d_cyc   = cyc;
        end
        if (prev_gnt && mem_req) dup_cnt++;
        prev_gnt = mem_gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, ib, db, d_seen, i_seen, n, req_cyc, bad;
        logic [15:0] seq;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) tick();

        check_eq("rst_mem_req",  64'(mem_req),  64'd0);
        check_eq("rst_if_ready", 64'(if_ready), 64'd0);
        check_eq("rst_d_ready",  64'(d_ready),  64'd0);
        check_eq("rst_owner",    64'(owner),    64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_rdata",    64'({if_rdata, d_rdata}), 64'd0);
        rst = 1'b0;
        tick();

        // Single fetch at minimum latency
        gnt_dly = 0; rv_dly = 0;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        t0 = cyc; ib = if_rdy_cnt;
        tick();
        check_eq("fetch_mem_req", 64'(mem_req), 64'd1);
        check_eq("fetch_owner", 64'(owner), 64'd1);
        check_eq("fetch_we_be_wdata", 64'({mem_we, mem_be, mem_wdata}), 64'd0);
        check_eq("fetch_addr", 64'(mem_addr), 64'h100);
        wait_cnt("fetch", 1'b0, ib + 1, 20);
        check_eq("fetch_latency", 64'(last_if_cyc), 64'(t0 + 3));
        check_eq("fetch_rdata", 64'(last_if_rdata), 64'h0050_0093);
        @(posedge clk); #1;
        if_req = 1'b0;
        tick();
        check_eq("fetch_owner_idle", 64'(owner), 64'd0);

        // Simultaneous store and fetch: store goes first
        gq.delete();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
        ib = if_rdy_cnt; db = d_rdy_cnt;
        wait_cnt("simul_d", 1'b1, db + 1, 30);
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        wait_cnt("simul_if", 1'b0, ib + 1, 30);
        @(posedge clk); #1;
        if_req = 1'b0;
        check_eq("simul_grants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            check_eq("simul_first_store", 64'({gq[0].own, gq[0].we, gq[0].be}), 64'({2'd2, 1'b1, 4'hF}));
            check_eq("simul_store_addr", 64'(gq[0].addr), 64'h2000);
            check_eq("simul_store_wdata", 64'(gq[0].wdata), 64'hDEAD_BEEF);
            check_eq("simul_second_fetch", 64'({gq[1].own, gq[1].we, gq[1].be, gq[1].wdata}), 64'({2'd1, 1'b0, 4'h0, 32'h0}));
            check_eq("simul_fetch_addr", 64'(gq[1].addr), 64'h104);
        end
        check_eq("simul_fetch_rdata", 64'(last_if_rdata), 64'h1000_0104);
        tick();

        // Starvation guard: four data grants, then fetch, then data again
        gq.delete();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0000_3000; d_wdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h0000_0108;
        d_seen = 0; i_seen = 0; n = 0;
        while (((d_seen < 6) || (i_seen < 2)) && (n < 300)) begin
            tick();
            n++;
            if (d_ready) begin
                d_seen++;
                @(posedge clk); #1;
                if (d_seen == 6) d_req = 1'b0;
                else d_addr += 32'd4;
            end else if (if_ready) begin
                i_seen++;
                @(posedge clk); #1;
                if (i_seen == 2) if_req = 1'b0;
                else if_addr += 32'd4;
            end
        end
        check_eq("starve_d_count", 64'(d_seen), 64'd6);
        check_eq("starve_if_count", 64'(i_seen), 64'd2);
        seq = 16'h0;
        foreach (gq[i]) seq = {seq[13:0], gq[i].own};
        check_eq("starve_grants", 64'(gq.size()), 64'd8);
        check_eq("starve_owner_seq", 64'(seq), 64'hAA69);
        if (gq.size() == 8) begin
            check_eq("starve_if_addr", 64'(gq[4].addr), 64'h108);
            check_eq("starve_resume_addr", 64'(gq[5].addr), 64'h3010);
            check_eq("starve_last_if_addr", 64'(gq[7].addr), 64'h10C);
        end
        tick();

        // Slow memory: request and fields held through a 3-cycle grant delay
        gnt_dly = 3; rv_dly = 5;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h0000_4000; d_wdata = 32'hCAFE_F00D;
        t0 = cyc; db = d_rdy_cnt;
        req_cyc = 0; bad = 0; n = 0;
        while ((d_rdy_cnt == db) && (n < 40)) begin
            tick();
            n++;
            if (mem_req) begin
                req_cyc++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'h3, 32'h0000_4000, 32'hCAFE_F00D})
                    bad++;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        check_eq("slow_req_cycles", 64'(req_cyc), 64'd4);
        check_eq("slow_fields_stable", 64'(bad), 64'd0);
        check_eq("slow_latency", 64'(last_d_cyc), 64'(t0 + 11));
        check_eq("slow_rdata", 64'(last_d_rdata), 64'h1000_4000);
        repeat (4) tick();
        check_eq("slow_one_pulse", 64'(d_rdy_cnt), 64'(db + 1));

        // Flush: fetch dropped in WAIT, pending load granted afterwards
        gnt_dly = 0; rv_dly = 3;
        gq.delete();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        ib = if_rdy_cnt; db = d_rdy_cnt;
        tick();
        tick();
        check_eq("flush_in_wait", 64'({mem_req, owner}), 64'({1'b0, 2'd1}));
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000;
        wait_cnt("flush_d", 1'b1, db + 1, 30);
        @(posedge clk); #1;
        d_req = 1'b0;
        check_eq("flush_no_if_ready", 64'(if_rdy_cnt), 64'(ib));
        check_eq("flush_grants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            check_eq("flush_order", 64'({gq[0].own, gq[1].own}), 64'({2'd1, 2'd2}));
            check_eq("flush_d_addr", 64'(gq[1].addr), 64'h5000);
        end
        check_eq("flush_d_rdata", 64'(last_d_rdata), 64'h1000_5000);
        tick();

        // Reset mid-WAIT, late response must be ignored
        gnt_dly = 0; rv_dly = 4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000;
        db = d_rdy_cnt;
        tick();
        tick();
        check_eq("rstw_pre_owner", 64'(owner), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rstw_mem_req", 64'(mem_req), 64'd0);
        check_eq("rstw_owner", 64'(owner), 64'd0);
        check_eq("rstw_readys", 64'({if_ready, d_ready}), 64'd0);
        check_eq("rstw_mem_addr", 64'(mem_addr), 64'd0);
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check_eq("rstw_no_d_ready", 64'(d_rdy_cnt), 64'(db));
        check_eq("rstw_d_rdata", 64'(d_rdata), 64'd0);
        check_eq("rstw_idle", 64'({mem_req, owner}), 64'd0);
        check_eq("no_dup_mem_req", 64'(dup_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage).
- Each port holds its request until it receives a one-cycle ready pulse; the pipeline stalls the stage while req && !ready.
- Data requests have priority because they are older in the pipeline. A streak counter stops fetch from starving.
- At most one memory transaction is outstanding at any time.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while if_req is pending; the next grant then goes to IF. Range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch request; held until if_ready, may be dropped by a flush
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetch data; valid when if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held with all fields stable until d_ready
- d_we  in  1  1=store, 0=load
- d_be  in  4  byte enables for stores
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid when d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request; held until mem_gnt
- mem_we  out  1  write enable to memory
- mem_be  out  4  byte enables to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response (read data or write ack); exactly one per accepted request
- mem_rdata  in  DW  memory read data
- owner  out  2  current owner: 0=none, 1=IF, 2=DATA

Behaviour:
- Reset values: state=IDLE; all outputs 0; streak=0; request registers 0.
- States:
  - IDLE: if d_req && !(if_req && streak==MAX_D_STREAK), latch the DATA request; else if if_req, latch the IF request; else stay. On a latch, go to REQ.
  - REQ: mem_req=1, fields driven from the latched registers. On mem_gnt go to WAIT, else stay.
  - WAIT: on mem_rvalid, register mem_rdata into the owner's rdata register and go to RESP.
  - RESP: pulse the owner's ready for one cycle, then go to IDLE.
- No arbitration happens in RESP. The requester updates req/fields at the RESP edge; IDLE samples them next cycle.
- Minimum latency: request seen in IDLE at cycle T → mem_req at T+1 → (gnt at T+1, rvalid at T+2) → ready at T+3. Back-to-back grants occur every 4 cycles minimum.
- mem_* outputs are registered. mem_we, mem_be and mem_wdata are 0 for IF transactions.
- mem_req may be held high for multiple cycles; its fields are stable until gnt. mem_rvalid is ignored outside WAIT.
- Streak counter:
  - Increments on each DATA grant made while if_req=1, saturating at MAX_D_STREAK.
  - Clears on an IF grant, or on a DATA grant made while if_req=0.
- Fetch flush: if if_req=0 during the RESP cycle of an IF transaction, suppress if_ready. The memory transaction still completes; there is no abort on the memory side.
- d_req must not drop while outstanding (protocol violation, assertion only). d_ready is always pulsed.
- if_rdata and d_rdata hold their last value between pulses.
- Simultaneous d_req and if_req in IDLE with streak<MAX go to DATA. With streak==MAX, IF wins.
- Reset mid-transaction: immediate return to IDLE with outputs cleared. Any in-flight memory response after reset is ignored (state is not WAIT).
- owner is 1 or 2 from the latch until the end of RESP, else 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, REQ, WAIT, RESP}
  - owner enum {OWN_NONE, OWN_IF, OWN_D}
  - packed struct mem_xact_t {we, be[3:0], addr, wdata}
  - constant OWN_W=2
- One module. FSM, streak counter and latched mem_xact_t stay inline; no sub-module is warranted.

Test Plan:
- Single fetch: if_req=1 with if_addr=0x100; memory grants immediately and returns 0x00500093 one cycle later. Required: if_ready at T+3 with if_rdata=0x00500093, mem_we=0, owner=1 during the transaction.
- Simultaneous requests: if_req with 0x104, plus d_req store (addr 0x2000, wdata 0xDEADBEEF, be=0xF). Required: store issued first with mem_we=1, d_ready pulses, then fetch issued, then if_ready.
- Starvation guard (MAX_D_STREAK=4): d_req held continuously with 6 back-to-back loads, if_req high throughout. Required: exactly 4 DATA grants, then 1 IF grant, then DATA resumes with the streak cleared.
- Slow memory: mem_gnt delayed 3 cycles and mem_rvalid delayed 5 cycles. Required: mem_req and fields stable during the delay, one d_ready pulse, no duplicate mem_req after gnt.
- Flush: if_req dropped while in WAIT. Required: memory transaction completes, no if_ready pulse, return to IDLE, a pending d_req is granted next.
- Reset mid-WAIT: rst asserted asynchronously. Required: mem_req=0, if_ready=d_ready=0, owner=0 immediately. A late mem_rvalid after reset produces no ready pulse.
